// File: rtl/lifo_arb_pkg.sv
// Shared constants and width helpers for the LIFO arbiter slice.
package lifo_arb_pkg;

  localparam logic OP_PUSH    = 1'b0;
  localparam logic OP_POP     = 1'b1;
  localparam int   LIFO_DEPTH = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((1 << i) < n) ? (i + 1) : r;
    end
    return r;
  endfunction

  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // count spans 0..LIFO_DEPTH inclusive
  localparam int CNT_W = clog2(LIFO_DEPTH + 1);

endpackage

// File: rtl/lifo_arbiter_rr_pick.sv
// Rotating-priority picker: grants the first eligible requester at or after ptr.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot_s;
  logic [IW-1:0] off_s;
  logic [IW:0]   sum_s;

  assign rot_s = N'({elig, elig} >> ptr);

  // lowest set bit of the rotated vector is the offset from the pointer
  always_comb begin
    off_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? IW'(i) : off_s;
    end
  end

  assign any   = |rot_s;
  assign sum_s = {1'b0, ptr} + {1'b0, off_s};
  assign idx   = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : IW'(sum_s);
  assign gnt   = any ? (N'(1'b1) << idx) : '0;

endmodule

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sequencing NREQ push/pop requesters onto one shared LIFO.
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 8,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               lifo_we,
  output logic               lifo_re,
  output logic [DW-1:0]      lifo_datain,
  input  logic [DW-1:0]      lifo_dataout,
  input  logic               lifo_full,
  input  logic               lifo_empty,
  output logic               busy
);

  logic             we_r, re_r, rsp_valid_r, lock_r;
  logic [DW-1:0]    datain_r;
  logic [IDW-1:0]   issue_id_r, rsp_id_r, ptr_r, lock_id_r;
  logic [CNT_W-1:0] cnt_r;

  logic             pfull_s, pempty_s, lock_hit_s, pick_any_s, any_s;
  logic             win_op_s, win_lock_s;
  logic [NREQ-1:0]  elig_s, pick_gnt_s, gnt_s;
  logic [IDW-1:0]   pick_idx_s, win_s, ptr_nxt_s;
  logic [DW-1:0]    win_data_s;

  // flags trail the issue stage by a cycle, so account for the pending command
  assign pfull_s  = lifo_full  | ((cnt_r == CNT_W'(LIFO_DEPTH - 1)) & we_r);
  assign pempty_s = lifo_empty | ((cnt_r == CNT_W'(1)) & re_r);

  // per-requester eligibility and whether the lock holder can be served again
  always_comb begin
    elig_s     = '0;
    lock_hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      elig_s[k]  = req[k] & ((req_op[k] == OP_PUSH) ? ~pfull_s : ~pempty_s);
      lock_hit_s = lock_hit_s | (lock_r & (lock_id_r == IDW'(k)) & elig_s[k]);
    end
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .elig (elig_s),
    .ptr  (ptr_r),
    .gnt  (pick_gnt_s),
    .any  (pick_any_s),
    .idx  (pick_idx_s)
  );

  assign any_s     = lock_hit_s | pick_any_s;
  assign win_s     = lock_hit_s ? lock_id_r : pick_idx_s;
  assign gnt_s     = lock_hit_s ? (NREQ'(1'b1) << lock_id_r) : pick_gnt_s;
  assign ptr_nxt_s = (win_s == IDW'(NREQ - 1)) ? '0 : win_s + IDW'(1);

  // select the winning requester's command fields
  always_comb begin
    win_data_s = '0;
    win_op_s   = OP_PUSH;
    win_lock_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      win_data_s = (win_s == IDW'(k)) ? req_data[k*DW +: DW] : win_data_s;
      win_op_s   = (win_s == IDW'(k)) ? req_op[k]            : win_op_s;
      win_lock_s = (win_s == IDW'(k)) ? req_lock[k]          : win_lock_s;
    end
  end

  // issue register, response pipe, fill count, RR pointer and lock state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_r        <= 1'b0;
      re_r        <= 1'b0;
      datain_r    <= '0;
      issue_id_r  <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      cnt_r       <= '0;
      ptr_r       <= '0;
      lock_r      <= 1'b0;
      lock_id_r   <= '0;
    end else begin
      we_r        <= any_s & (win_op_s == OP_PUSH);
      re_r        <= any_s & (win_op_s == OP_POP);
      datain_r    <= (any_s & (win_op_s == OP_PUSH)) ? win_data_s : '0;
      issue_id_r  <= any_s ? win_s : issue_id_r;
      rsp_valid_r <= re_r;
      rsp_id_r    <= re_r ? issue_id_r : rsp_id_r;
      case ({we_r, re_r})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
      ptr_r     <= (any_s & ~lock_hit_s) ? ptr_nxt_s : ptr_r;
      lock_r    <= any_s & win_lock_s;
      lock_id_r <= win_s;
    end
  end

  assign gnt         = gnt_s;
  assign lifo_we     = we_r;
  assign lifo_re     = re_r;
  assign lifo_datain = datain_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_id      = rsp_id_r;
  assign rsp_data    = rsp_valid_r ? lifo_dataout : '0;
  assign busy        = re_r | rsp_valid_r;

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit, 16-deep LIFO between NREQ requesters.
- Each requester issues push or pop commands through a req/gnt handshake. The block drives the LIFO's we/re/datain and routes popped data back to the requester that issued the pop.
- Sits between client blocks and the LIFO instance. It is the only master of the LIFO write and read enables.

Parameters:
- NREQ, 2, number of requesters (2..4)
- DW, 8, data width, matches the LIFO
- IDW, 1, requester-ID width, equal to clog2(NREQ) with a minimum of 1

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester command request
- req_op  in  NREQ  per-requester op: 0 = push, 1 = pop
- req_lock  in  NREQ  keep the grant on this requester for the next cycle
- req_data  in  NREQ*DW  push data; requester k occupies bits [k*DW +: DW]
- gnt  out  NREQ  one-hot; command accepted this cycle
- rsp_valid  out  1  pop data valid
- rsp_id  out  IDW  requester that issued the returned pop
- rsp_data  out  DW  popped data
- lifo_we  out  1  to LIFO we
- lifo_re  out  1  to LIFO re
- lifo_datain  out  DW  to LIFO datain
- lifo_dataout  in  DW  from LIFO dataout; registered, valid the cycle after lifo_re
- lifo_full  in  1  from LIFO
- lifo_empty  in  1  from LIFO
- busy  out  1  pop response outstanding

Behaviour:
- Reset (resetn=0, asynchronous): gnt=0, lifo_we=0, lifo_re=0, lifo_datain=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Reset also sets the RR pointer to 0 (requester 0 highest priority) and clears the lock.
- Reset mid-operation drops any outstanding pop response; no rsp_valid is produced for it.
- Eligibility, per cycle: requester k is eligible when req[k]=1 and one of:
  - push (req_op[k]=0) with lifo_full=0;
  - pop (req_op[k]=1) with lifo_empty=0.
  - Ineligible requests wait; they are never dropped or NACKed.
- Arbitration is combinational and picks at most one eligible requester per cycle.
- Search order starts at the RR pointer. Once a requester is granted, the pointer moves to (winner+1) mod NREQ at the clock edge.
- gnt is combinational, same cycle as the request. The requester must hold req, req_op and req_data stable until gnt is seen.
- Issue is registered: the command granted in cycle N drives the LIFO in cycle N+1.
  - Push: lifo_we=1, lifo_datain=req_data slice. lifo_we and lifo_re are never both 1.
  - Pop: lifo_re=1. In cycle N+2, rsp_valid=1 with rsp_id=winner and rsp_data=lifo_dataout. rsp_valid is a 1-cycle pulse.
- Pop latency from gnt to rsp_valid is 2 cycles.
- Back-to-back operations at one per cycle are supported.
- Flag hazard: LIFO flags lag the issue register by one cycle. The arbiter therefore keeps an internal count, cnt (0..16), updated on issue.
  - Eligibility uses the projected state, not the raw LIFO flags:
    - projected-full = lifo_full OR (cnt=15 and an issue-stage push is pending);
    - projected-empty = lifo_empty OR (cnt=1 and an issue-stage pop is pending).
  - Result: no push is ever issued to a full LIFO and no pop to an empty one.
- Lock: if the current winner has req_lock=1 and its next command is eligible, it is granted again regardless of the RR pointer, and the pointer does not advance.
  - The lock is released when req_lock=0 or req drops.
  - If the locked requester's command is ineligible (e.g. a pop while empty), the lock is released that cycle and normal RR applies.
- busy=1 from the cycle lifo_re is asserted until the cycle rsp_valid is asserted.
- Simultaneous push and pop requests from different requesters are ordered by RR only. No preference is given to either op type.
- Data and flags are unaffected when NREQ=1 (degenerate case: the pointer stays at 0).

Decomposition:
- Package lifo_arb_pkg holds:
  - op encoding constants OP_PUSH=1'b0, OP_POP=1'b1;
  - LIFO_DEPTH=16;
  - clog2 function for IDW.
- Sub-module rr_pick (NREQ-wide rotate-priority one-hot picker, combinational) is natural. It is instantiated once.
- Issue register, response pipeline, count and lock live in lifo_arbiter.

Test Plan:
- Reset then idle: all outputs 0 and busy=0. Assert resetn=0 mid-pop (gnt seen, rsp pending) -> rsp_valid never pulses and all outputs return to 0.
- Req0 pushes 0x11, 0x22, 0x33 with lock=1 -> gnt[0] in 3 consecutive cycles and lifo_we pulses carry the data in order. Then req1 pops 3 times -> rsp_data 0x33, 0x22, 0x11, each with rsp_id=1, 2 cycles after each gnt.
- Both requesters push continuously, lock=0 -> gnt alternates 0,1,0,1... At 16 pushes gnt stops with no 17th lifo_we, even on the cycle when lifo_full has not yet risen.
- Pop request on an empty LIFO -> no gnt and no lifo_re. A later push by req1 of 0xA5 -> pop granted 2 cycles after the push gnt, rsp_data=0xA5.
- Req0 pops and req1 pushes 0x5A in the same cycle with the RR pointer at 1 -> req1 is granted first and req0 next. rsp_data=0x5A, rsp_id=0.
- Fill to 15 entries, then push and pop in consecutive cycles -> cnt returns to 15 and no over- or underflow occurs. A locked requester hitting full -> lock released and the other requester's pop is granted.
